// File: rtl/bitpack_fifo.sv
// Packs sparse per-lane valid bits into WORD_W-bit words and queues them
// in a small word FIFO with valid/ready output, flush and drop accounting.
module bitpack_fifo #(
  parameter int IN_LANES = 6,
  parameter int WORD_W   = 16,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [IN_LANES-1:0]       in_valid,
  input  logic [IN_LANES-1:0]       in_bits,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WORD_W-1:0]         out_word,
  output logic [$clog2(WORD_W)-1:0] fill,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int FW = $clog2(WORD_W);
  localparam int IW = FW + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [IW-1:0] WORD_L = IW'(WORD_W);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WORD_W-1:0]   acc_q;
  logic [FW-1:0]       fill_q;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [LW-1:0]       count;
  logic                ovf_q;
  logic [CNT_W-1:0]    drop_q;

  logic [2*WORD_W-1:0] comp;
  logic [IW-1:0]       n;
  logic [IW-1:0]       sum;
  logic [2*WORD_W-1:0] merged;
  logic                done;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic [WORD_W-1:0]   acc_n;
  logic [FW-1:0]       fill_n;
  logic                pop;
  logic                full;
  logic                wr_en;
  logic                drop;

  // Gather valid bits densely, lowest lane first.
  always_comb begin
    comp = '0;
    n    = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      if (in_valid[i]) begin
        comp[n] = in_bits[i];
        n       = n + IW'(1);
      end
    end
  end

  assign sum    = {1'b0, fill_q} + n;
  assign merged = {{WORD_W{1'b0}}, acc_q} | (comp << fill_q);
  assign done   = !flush && (sum >= WORD_L);

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    acc_n     = merged[WORD_W-1:0];
    fill_n    = sum[FW-1:0];
    if (flush) begin
      push      = (fill_q != '0);
      push_word = acc_q;
      acc_n     = '0;
      fill_n    = '0;
    end else if (done) begin
      push      = 1'b1;
      push_word = merged[WORD_W-1:0];
      acc_n     = merged[2*WORD_W-1:WORD_W];
      fill_n    = FW'(sum - WORD_L);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_n;
      fill_q <= fill_n;
    end
  end

  // Pop is resolved first so a full FIFO being drained can still accept.
  assign pop   = (count != '0) && out_ready;
  assign full  = (count == DEPTH_L);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        (wr_en && !pop): count <= count + LW'(1);
        (!wr_en && pop): count <= count - LW'(1);
        default:         count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign out_valid = (count != '0);
  assign out_word  = out_valid ? mem[rd_ptr] : '0;
  assign fill      = fill_q;
  assign level     = count;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_bitpack_fifo.sv
// Directed and random bench for bitpack_fifo against a bit-queue model.
module tb_bitpack_fifo;

  localparam int L = 6;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [L-1:0] in_valid = '0;
  logic [L-1:0] in_bits = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;

  logic         out_valid, out_valid2;
  logic [W-1:0] out_word, out_word2;
  logic [3:0]   fill, fill2;
  logic [2:0]   level, level2;
  logic         overflow, overflow2;
  logic [7:0]   drop_cnt;
  logic [1:0]   drop_cnt2;

  bitpack_fifo #(.IN_LANES(L), .WORD_W(W), .DEPTH(D), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bits(in_bits),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_word(out_word), .fill(fill), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  bitpack_fifo #(.IN_LANES(L), .WORD_W(W), .DEPTH(D), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bits(in_bits),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid2),
    .out_word(out_word2), .fill(fill2), .level(level2),
    .overflow(overflow2), .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit           m_bits[$];
  logic [W-1:0] m_words[$];
  int           m_drops;
  bit           m_ovf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] head();
    return (m_words.size() > 0) ? m_words[0] : '0;
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_words.size() > 0));
    chk("out_word", 32'(out_word), 32'(head()));
    chk("fill", 32'(fill), 32'(m_bits.size()));
    chk("level", 32'(level), 32'(m_words.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
    chk("drop_cnt_sat", 32'(drop_cnt2), 32'((m_drops > 3) ? 3 : m_drops));
    chk("out_word_b", 32'(out_word2), 32'(head()));
  endtask

  task automatic model_step(input logic [L-1:0] v, input logic [L-1:0] b,
                            input logic fl, input logic rdy);
    logic [W-1:0] w;
    bit has;
    has = 0;
    w = '0;
    if (m_words.size() > 0 && rdy) void'(m_words.pop_front());
    if (fl) begin
      if (m_bits.size() > 0) begin
        for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
        has = 1;
        m_bits.delete();
      end
    end else begin
      for (int i = 0; i < L; i++) if (v[i]) m_bits.push_back(b[i]);
      if (m_bits.size() >= W) begin
        for (int i = 0; i < W; i++) w[i] = m_bits.pop_front();
        has = 1;
      end
    end
    if (has) begin
      if (m_words.size() < D) m_words.push_back(w);
      else begin
        m_drops++;
        m_ovf = 1;
      end
    end
  endtask

  task automatic cyc(input logic [L-1:0] v, input logic [L-1:0] b,
                     input logic fl, input logic rdy);
    in_valid  = v;
    in_bits   = b;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    model_step(v, b, fl, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    m_bits.delete();
    m_words.delete();
    m_drops = 0;
    m_ovf   = 0;
    #1;
    check_all();
    chk("rst_word", 32'(out_word), 32'h0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [L-1:0] rb;
    m_drops = 0;
    m_ovf   = 0;
    #12 reset_n = 1'b1;

    // Reset, then idle with nothing pending
    cyc('0, '0, 0, 1);
    do_reset();
    cyc('0, '0, 0, 1);
    chk("idle_valid", 32'(out_valid), 32'h0);

    // Full lanes
    do_reset();
    for (int i = 0; i < 3; i++) cyc(6'h3F, 6'b101010, 0, 1);
    chk("full_word", 32'(out_word), 32'hAAAA);
    chk("full_fill", 32'(fill), 32'd2);
    chk("full_level", 32'(level), 32'd1);
    cyc('0, '0, 0, 1);
    chk("full_popped", 32'(level), 32'd0);

    // Sparse lanes
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(6'b100001, 6'b100000, 0, 0);
      if (i < 7) chk("sparse_fill", 32'(fill), 32'(2 * (i + 1)));
    end
    chk("sparse_word", 32'(out_word), 32'hAAAA);
    chk("sparse_fill0", 32'(fill), 32'd0);

    // Overflow: six words with backpressure
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rb = L'($urandom);
      cyc(6'h3F, rb, 0, 0);
    end
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    cyc(6'h3F, 6'h15, 0, 0);
    cyc(6'h3F, 6'h2A, 0, 0);
    cyc(6'h3F, 6'h33, 0, 1);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 5; i++) cyc('0, '0, 0, 1);
    chk("drain_level", 32'(level), 32'd0);

    // Flush
    do_reset();
    cyc(6'h1F, 6'h1F, 0, 0);
    chk("pre_flush_fill", 32'(fill), 32'd5);
    cyc(6'h3F, 6'h3F, 1, 0);
    chk("flush_word", 32'(out_word), 32'h001F);
    chk("flush_fill", 32'(fill), 32'd0);
    cyc(6'h3F, 6'h3F, 1, 0);
    chk("flush_empty", 32'(level), 32'd1);

    // Saturation and mid-stream reset
    do_reset();
    for (int i = 0; i < 24; i++) begin
      rb = L'($urandom);
      cyc(6'h3F, rb, 0, 0);
    end
    chk("sat_drop8", 32'(drop_cnt), 32'd5);
    chk("sat_drop2", 32'(drop_cnt2), 32'd3);
    do_reset();
    for (int i = 0; i < 9; i++) cyc(6'h3F, 6'h3F, 0, 0);
    cyc(6'h07, 6'h07, 0, 0);
    chk("mid_fill", 32'(fill), 32'd9);
    chk("mid_level", 32'(level), 32'd3);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(6'b000011, 6'b000010, 0, 0);
    chk("post_rst_word", 32'(out_word), 32'hAAAA);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(L'($urandom), L'($urandom), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
